product_accumulator: RTL and testbench

- Downstream consumer of the 3x3-bit array multiplier's 6-bit product.
- Sums a group of up to N_TERMS products into one dot-product result, using valid/ready handshakes on both sides.
- Sits between the multiplier output and the result register or bus.
- One group in flight at a time; the result is held until the consumer accepts it.

---
 rtl/acc_pkg.sv | 21 ++
 rtl/product_accumulator.sv | 99 +++++++++
 tb/tb_product_accumulator.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: definitions shared by the multiplier datapath and product_accumulator.
//   state_t    - accumulator FSM states (IDLE, ACC, DONE)
//   PROD_W     - width of the 3x3-bit multiplier product
//   acc_width  - accumulator width that cannot overflow for a given term count
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam int unsigned PROD_W = 6;

  // Summing n values of pw bits needs $clog2(n) extra bits of headroom.
  function automatic int unsigned acc_width(input int unsigned pw,
                                            input int unsigned n);
    return pw + $clog2(n);
  endfunction

endpackage

// File: rtl/product_accumulator.sv
// product_accumulator: sums a group of up to N_TERMS unsigned products into
// one result, with valid/ready handshakes on input and output.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - product handshake; in_ready depends only on state
//   in_prod             - unsigned product (PW bits)
//   in_last             - closes the group early on an accepted beat
//   out_valid/out_ready - result handshake; result held until accepted
//   out_sum             - group sum (ACC_W bits), held outside DONE
//   out_count           - number of products in the group (CW bits)
module product_accumulator
  import acc_pkg::*;
#(
  parameter  int unsigned PW      = PROD_W,
  parameter  int unsigned N_TERMS = 4,
  localparam int unsigned ACC_W   = acc_width(PW, N_TERMS),
  localparam int unsigned CW      = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count
);

  // Count value at which the next accepted product fills the group.
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    count;

  logic             accept;
  logic             closing;
  logic [ACC_W-1:0] acc_next;
  logic [CW-1:0]    count_next;

  assign in_ready = (state != DONE);

  // Next accumulator/count on an accepted beat; IDLE starts a fresh group.
  always_comb begin
    accept     = in_valid && in_ready;
    acc_next   = acc + ACC_W'(in_prod);
    count_next = count + CW'(1);
    closing    = in_last || (count == LAST_CNT);
    if (state == IDLE) begin
      acc_next   = ACC_W'(in_prod);
      count_next = CW'(1);
      closing    = in_last || (N_TERMS == 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= acc_next;
            count <= count_next;
            if (closing) begin
              // Result registers load with the closing beat so out_valid
              // and the data appear together the following cycle.
              state     <= DONE;
              out_valid <= 1'b1;
              out_sum   <= acc_next;
              out_count <= count_next;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and randomized checks of product_accumulator
// against a group-level reference model (queue of accepted products).
module tb_product_accumulator;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_prod = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic [2:0] out_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: products of the open group, plus the last closed result.
  int unsigned grp[$];
  bit          have_result = 1'b0;
  int unsigned exp_sum = 0;
  int unsigned exp_cnt = 0;

  product_accumulator #(.N_TERMS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got,
                       input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("in_ready", in_ready, !have_result);
    check("out_valid", out_valid, have_result);
    check("out_sum", out_sum, exp_sum);
    check("out_count", out_count, exp_cnt);
  endtask

  task automatic model_reset();
    grp.delete();
    have_result = 1'b0;
    exp_sum = 0;
    exp_cnt = 0;
  endtask

  // Apply the group rules to the inputs that the next rising edge samples.
  task automatic model_update();
    int unsigned s;
    if (have_result) begin
      if (out_ready) have_result = 1'b0;
    end else if (in_valid) begin
      grp.push_back(int'(in_prod));
      if (in_last || grp.size() == N) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        exp_sum = s;
        exp_cnt = grp.size();
        grp.delete();
        have_result = 1'b1;
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, then drive new inputs.
  task automatic step(input bit v, input int unsigned p, input bit l,
                      input bit r);
    @(negedge clk);
    compare_all();
    in_valid  = v;
    in_prod   = 6'(p);
    in_last   = l;
    out_ready = r;
    model_update();
  endtask

  task automatic expect_out(input string tag, input int unsigned s,
                            input int unsigned c);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_sum"}, out_sum, s);
    check({tag, "_count"}, out_count, c);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_sum"}, out_sum, 0);
    check({tag, "_count"}, out_count, 0);
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    mid_reset("rst_init");

    // Full group at the multiplier maximum, back-to-back.
    for (int i = 0; i < 4; i++) step(1, 49, 0, 1);
    step(0, 0, 0, 1);
    expect_out("full", 196, 4);
    step(0, 0, 0, 1);
    check("full_idle_valid", out_valid, 0);
    check("full_idle_ready", in_ready, 1);

    // Early close, then a group of one.
    step(1, 10, 0, 1);
    step(1, 20, 1, 1);
    step(0, 0, 0, 1);
    expect_out("early", 30, 2);
    step(1, 7, 1, 1);
    step(0, 0, 0, 1);
    expect_out("single", 7, 1);

    // Backpressure with pulsing in_valid; pending product accepted after.
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    step(1, 4, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(i % 2 == 0, 9, 1, 0);
      expect_out("bp", 10, 4);
    end
    step(1, 9, 1, 1);
    step(1, 9, 1, 1);
    step(0, 0, 0, 1);
    expect_out("bp_next", 9, 1);

    // Input gaps; closes on reaching N_TERMS; last together with full count.
    step(1, 3, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 5, 0, 1);
    step(0, 0, 0, 1);
    step(1, 6, 0, 1);
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    expect_out("gaps", 15, 4);
    step(0, 0, 0, 1);

    // Reset mid-group discards the partial sum.
    step(1, 40, 0, 1);
    step(1, 40, 0, 1);
    mid_reset("rst_mid");
    for (int i = 1; i <= 4; i++) step(1, i, 0, 1);
    step(0, 0, 0, 1);
    expect_out("after_rst", 10, 4);

    // Reset while a result is pending drops it immediately.
    mid_reset("rst_done");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(9, 0) < 7, $urandom_range(63, 0),
           $urandom_range(3, 0) == 0, $urandom_range(9, 0) < 6);
      if (i == 300) begin
        step(0, 0, 0, 0);
        mid_reset("rst_rand");
      end
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
